// File: rtl/register_file_legv8_pkg.sv
// Shared constants for the LEGv8 register file. The ALU and the control/decode
// block use the same widths and the XZR index.
//   DATA_WIDTH     : width of each register and of all data ports
//   REG_ADDR_WIDTH : register address width
//   REG_COUNT      : number of architectural registers
//   ZERO_REG       : XZR index, always reads 0 and ignores writes
package register_file_legv8_pkg;

   localparam int DATA_WIDTH     = 64;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int REG_COUNT      = 1 << REG_ADDR_WIDTH;

   typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_REG = reg_addr_t'(31);

endpackage

// File: rtl/register_file_legv8_register_nbit.sv
// register_nbit: WIDTH-bit storage register with load enable and asynchronous
// active-low clear.
// Ports:
//   clock   in  rising-edge clock
//   reset_n in  async active-low clear (q -> 0 immediately)
//   load    in  capture d on the next rising edge
//   d       in  WIDTH-bit data in
//   q       out WIDTH-bit stored value
module register_nbit #(
   parameter int WIDTH = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/register_file_legv8.sv
// register_file_legv8: 32 x 64-bit LEGv8 general register file with two
// combinational read ports and one synchronous write port. X31 is XZR.
// Ports:
//   clock   in  system clock, writes on rising edge
//   reset_n in  async active-low reset, clears every register
//   SA, SB  in  read addresses for ports A and B
//   DA      in  write address
//   W       in  write enable
//   D       in  write data
//   A, B    out read data (ALU A operand / ALU B or immediate mux)
// Build option: define REGFILE_WRITE_BYPASS_EN to forward D onto a read port
// whose address matches an active write in the same cycle.
module register_file_legv8
   import register_file_legv8_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset_n,
   input  reg_addr_t             SA,
   input  reg_addr_t             SB,
   input  reg_addr_t             DA,
   input  logic                  W,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] A,
   output logic [DATA_WIDTH-1:0] B
);

   logic [REG_COUNT-1:0]  load;
   logic [DATA_WIDTH-1:0] regs [REG_COUNT];

   // Write decoder; XZR never gets a load enable.
   always_comb begin
      load = '0;
      if (W && (DA != ZERO_REG)) begin
         load[DA] = 1'b1;
      end
   end

   for (genvar i = 0; i < REG_COUNT; i++) begin : g_reg
      if (i == int'(ZERO_REG)) begin : g_xzr
         assign regs[i] = '0;
      end else begin : g_gpr
         register_nbit #(
            .WIDTH (DATA_WIDTH)
         ) u_reg (
            .clock   (clock),
            .reset_n (reset_n),
            .load    (load[i]),
            .d       (D),
            .q       (regs[i])
         );
      end
   end

   // Registers clear asynchronously, so reads during reset already return 0.
   always_comb begin
`ifdef REGFILE_WRITE_BYPASS_EN
      if (SA == ZERO_REG) begin
         A = '0;
      end else if (W && reset_n && (SA == DA)) begin
         A = D;
      end else begin
         A = regs[SA];
      end
      if (SB == ZERO_REG) begin
         B = '0;
      end else if (W && reset_n && (SB == DA)) begin
         B = D;
      end else begin
         B = regs[SB];
      end
`else
      A = (SA == ZERO_REG) ? '0 : regs[SA];
      B = (SB == ZERO_REG) ? '0 : regs[SB];
`endif
   end

endmodule

// File: tb/tb_register_file_legv8.sv
module tb_register_file_legv8;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [4:0]  SA, SB, DA;
   logic        W;
   logic [63:0] D, A, B;

   logic [63:0] model [32];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   register_file_legv8 dut (
      .clock   (clock),
      .reset_n (reset_n),
      .SA      (SA),
      .SB      (SB),
      .DA      (DA),
      .W       (W),
      .D       (D),
      .A       (A),
      .B       (B)
   );

   // Architectural view of a read given the current inputs.
   function automatic logic [63:0] expect_read(input logic [4:0] addr);
      if (addr == 5'd31) return 64'd0;
      if (!reset_n) return 64'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
      if (W && addr == DA) return D;
`endif
      return model[addr];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 64'd0;
   endtask

   // Rising edge: apply the write rule to the model, then settle.
   task automatic clock_edge();
      @(posedge clock);
      if (reset_n && W && DA != 5'd31) model[DA] = D;
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; W = 1'b0; DA = 5'd0; D = 64'd0; SA = 5'd5; SB = 5'd17;
      clear_model();
      repeat (2) @(negedge clock);
      #1;
      n_cmp++;
      if (A !== 64'd0) begin n_err++; $display("FAIL reset_a actual=%h required=%h", A, 64'd0); end
      n_cmp++;
      if (B !== 64'd0) begin n_err++; $display("FAIL reset_b actual=%h required=%h", B, 64'd0); end
      // first edge after release must accept a write
      @(negedge clock);
      reset_n = 1'b1; W = 1'b1; DA = 5'd5; D = 64'hDEAD;
      clock_edge();
      n_cmp++;
      if (A !== 64'hDEAD) begin n_err++; $display("FAIL first_write actual=%h required=%h", A, 64'hDEAD); end
      // async reset between edges clears immediately
      @(negedge clock);
      W = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++;
      if (A !== 64'd0) begin n_err++; $display("FAIL async_clear actual=%h required=%h", A, 64'd0); end
      clear_model();
      @(negedge clock);
      reset_n = 1'b1;
      #1;
      n_cmp++;
      if (A !== 64'd0) begin n_err++; $display("FAIL post_reset actual=%h required=%h", A, 64'd0); end
   endtask

   task automatic test_write_read();
      @(negedge clock);
      W = 1'b1; DA = 5'd3; D = 64'h0123456789ABCDEF;
      clock_edge();
      @(negedge clock);
      W = 1'b0; SA = 5'd3; SB = 5'd3;
      #1;
      n_cmp++;
      if (A !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL wr_rd_a actual=%h required=%h", A, 64'h0123456789ABCDEF); end
      n_cmp++;
      if (B !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL wr_rd_b actual=%h required=%h", B, 64'h0123456789ABCDEF); end
   endtask

   task automatic test_xzr();
      @(negedge clock);
      W = 1'b1; DA = 5'd31; D = '1;
      clock_edge();
      @(negedge clock);
      W = 1'b0; SA = 5'd31; SB = 5'd31;
      #1;
      n_cmp++;
      if (A !== 64'd0) begin n_err++; $display("FAIL xzr_a actual=%h required=%h", A, 64'd0); end
      n_cmp++;
      if (B !== 64'd0) begin n_err++; $display("FAIL xzr_b actual=%h required=%h", B, 64'd0); end
      for (int i = 0; i < 31; i++) begin
         SA = 5'(i);
         #1;
         n_cmp++;
         if (A !== model[i]) begin n_err++; $display("FAIL xzr_others reg=%0d actual=%h required=%h", i, A, model[i]); end
      end
   endtask

   task automatic test_same_addr();
      logic [63:0] pre;
      @(negedge clock);
      W = 1'b1; DA = 5'd7; D = 64'd1;
      clock_edge();
      @(negedge clock);
      W = 1'b1; DA = 5'd7; D = 64'd2; SA = 5'd7;
      #1;
`ifdef REGFILE_WRITE_BYPASS_EN
      pre = 64'd2;
`else
      pre = 64'd1;
`endif
      n_cmp++;
      if (A !== pre) begin n_err++; $display("FAIL rdw_before actual=%h required=%h", A, pre); end
      clock_edge();
      n_cmp++;
      if (A !== 64'd2) begin n_err++; $display("FAIL rdw_after actual=%h required=%h", A, 64'd2); end
      @(negedge clock);
      W = 1'b0;
   endtask

   task automatic test_reset_mid_write();
      @(negedge clock);
      W = 1'b1; DA = 5'd9; D = 64'h55;
      #2 reset_n = 1'b0;
      @(posedge clock);
      #1;
      clear_model();
      @(negedge clock);
      reset_n = 1'b1; W = 1'b0; SA = 5'd9; SB = 5'd3;
      #1;
      n_cmp++;
      if (A !== 64'd0) begin n_err++; $display("FAIL mid_write_lost actual=%h required=%h", A, 64'd0); end
      n_cmp++;
      if (B !== 64'd0) begin n_err++; $display("FAIL mid_write_cleared actual=%h required=%h", B, 64'd0); end
   endtask

   task automatic test_sweep();
      for (int i = 0; i < 31; i++) begin
         @(negedge clock);
         W = 1'b1; DA = 5'(i); D = 64'(i) * 64'h1111;
         clock_edge();
      end
      @(negedge clock);
      W = 1'b0;
      for (int a = 0; a < 32; a++) begin
         for (int b = 0; b < 32; b++) begin
            SA = 5'(a); SB = 5'(b);
            #1;
            n_cmp++;
            if (A !== ((a == 31) ? 64'd0 : 64'(a) * 64'h1111)) begin
               n_err++; $display("FAIL sweep_a sa=%0d actual=%h required=%h", a, A, (a == 31) ? 64'd0 : 64'(a) * 64'h1111);
            end
            n_cmp++;
            if (B !== ((b == 31) ? 64'd0 : 64'(b) * 64'h1111)) begin
               n_err++; $display("FAIL sweep_b sb=%0d actual=%h required=%h", b, B, (b == 31) ? 64'd0 : 64'(b) * 64'h1111);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [63:0] ea, eb;
      for (int n = 0; n < 400; n++) begin
         @(negedge clock);
         W  = ($urandom_range(0, 3) != 0);
         DA = 5'($urandom_range(0, 31));
         D  = {$urandom, $urandom};
         SA = ($urandom_range(0, 3) == 0) ? DA : 5'($urandom_range(0, 31));
         SB = ($urandom_range(0, 3) == 0) ? SA : 5'($urandom_range(0, 31));
         #1;
         ea = expect_read(SA);
         eb = expect_read(SB);
         n_cmp++;
         if (A !== ea) begin n_err++; $display("FAIL rand_pre_a sa=%0d actual=%h required=%h", SA, A, ea); end
         n_cmp++;
         if (B !== eb) begin n_err++; $display("FAIL rand_pre_b sb=%0d actual=%h required=%h", SB, B, eb); end
         clock_edge();
         ea = expect_read(SA);
         eb = expect_read(SB);
         n_cmp++;
         if (A !== ea) begin n_err++; $display("FAIL rand_post_a sa=%0d actual=%h required=%h", SA, A, ea); end
         n_cmp++;
         if (B !== eb) begin n_err++; $display("FAIL rand_post_b sb=%0d actual=%h required=%h", SB, B, eb); end
      end
      @(negedge clock);
      W = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_xzr();
      test_same_addr();
      test_reset_mid_write();
      test_sweep();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/register_file_legv8.md
Name: register_file_legv8

Overview:
- 32-entry by 64-bit LEGv8 general register file sitting directly upstream of the ALU.
- Read port A drives the ALU A operand; read port B drives the B operand, either directly or via the immediate mux.
- The write port takes the writeback result: ALU F, memory data, or PC+4.
- Two combinational read ports and one synchronous write port; X31 is hardwired as XZR.

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- REG_COUNT, 32, number of architectural registers; address width is log2(REG_COUNT) = 5.
- ZERO_REG, 31, index that always reads 0 and ignores writes (XZR).

Ports:
- clock  input  1  single system clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- SA  input  5  read address, port A.
- SB  input  5  read address, port B.
- DA  input  5  write address.
- W  input  1  write enable.
- D  input  DATA_WIDTH  write data.
- A  output  DATA_WIDTH  read data, port A (to ALU A).
- B  output  DATA_WIDTH  read data, port B (to ALU B / immediate mux).

Interface note: one clock; reset is asynchronous and active-low.

Behaviour:
- Reset:
  - reset_n low clears all REG_COUNT registers to 0 immediately, without waiting for a clock edge.
  - While reset_n is low, A and B read 0 for every address and writes are ignored.
  - Release is synchronous to design intent: the first write can occur on the first rising edge with reset_n high.
- Write:
  - On rising clock, if reset_n = 1, W = 1 and DA != ZERO_REG, then reg[DA] <= D.
  - W = 0 holds all state.
  - W = 1 with DA = ZERO_REG is a legal no-op; no register changes.
- Read:
  - Purely combinational, zero latency.
  - A = (SA == ZERO_REG) ? 0 : reg[SA]; B likewise with SB.
  - SA == SB is legal; both ports return the same value.
- Read during write to the same address (no bypass): the read returns the old value during the cycle and the new value after the edge.
- Writeback timing: a value written at edge N is visible on A/B from edge N onward. This is one cycle of write-to-read latency, which the control unit accounts for.
- Reset asserted mid-cycle with W = 1: the write is lost and all registers read 0.
- No X propagation: every register has a defined reset value, and reads of out-of-range addresses cannot occur (5-bit address with REG_COUNT = 32).

Optional Feature:
- Macro REGFILE_WRITE_BYPASS_EN.
- When defined, same-cycle write-through applies: if W = 1, reset_n = 1, DA != ZERO_REG and SA == DA, then A = D combinationally; the same rule applies to B with SB. This removes one cycle of read-after-write latency for the pipelined datapath.
- When undefined, reads always return stored contents only, as described under Behaviour.
- XZR always reads 0 in both configurations.

Decomposition:
- Shared package holds:
  - DATA_WIDTH (64)
  - REG_ADDR_WIDTH (5)
  - ZERO_REG index (31)
  - a register address typedef
- The ALU and the control/decode block reuse these constants.
- Natural sub-module: register_nbit, a DATA_WIDTH-bit register with load enable and async active-low clear. It is instantiated REG_COUNT-1 times via generate, with the write decoder driving the load enables.
- Read muxes stay in the top module.

Test Plan:
- Reset: set reg[5] = 0xDEAD, then pulse reset_n low between edges -> A with SA = 5 reads 0 immediately, before any clock edge.
- Write/read: W = 1, DA = 3, D = 0x0123456789ABCDEF, then edge; W = 0, SA = 3, SB = 3 -> A = B = 0x0123456789ABCDEF.
- XZR: W = 1, DA = 31, D = all ones, then edge; SA = 31 -> A = 0; all other registers unchanged.
- Same-address read/write: reg[7] = 1; W = 1, DA = 7, D = 2, SA = 7 -> before the edge A = 1 (bypass undefined) or A = 2 (REGFILE_WRITE_BYPASS_EN); after the edge A = 2 in both.
- Reset mid-write: W = 1, DA = 9, D = 0x55, reset_n low across the edge -> reg[9] = 0 after reset release.
- Sweep: write i*0x1111 to X0..X30 and read all pairs on A/B -> every value matches; X31 = 0.
